r8b_regfile: RTL and testbench

Parametrised multi-port general-purpose register file for the pipelined r8b core. It replaces the per-register single-GPR instances and their tri-state output buses with one block holding NREGS registers. The block provides two operand read ports (LHS/RHS), one bus read port and one writeback port. A per-register busy scoreboard lets the decode stage detect read-after-write hazards and stall.

---
 rtl/r8b_pkg.sv | 11 +
 rtl/r8b_regfile_rdport.sv | 38 +++
 rtl/r8b_regfile.sv | 102 ++++++++++
 tb/tb_r8b_regfile.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/r8b_pkg.sv
// Shared types and default sizes for the r8b register file.
package r8b_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREGS = 8;
  localparam int DEF_AW    = $clog2(DEF_NREGS);

  typedef logic [DEF_AW-1:0]    reg_addr_t;
  typedef logic [DEF_WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/r8b_regfile_rdport.sv
// One register-file read port: address mux plus optional writeback forwarding
// (enabled by defining R8B_REGFILE_BYPASS_EN).
import r8b_pkg::*;

module r8b_regfile_rdport #(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int NREGS    = DEF_NREGS,
  parameter  int ZERO_REG = 0,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic [WIDTH-1:0] i_regs [NREGS],
  input  logic [NREGS-1:0] i_busy_vec,
  input  logic [AW-1:0]    i_addr,
  input  logic             i_wb_en,
  input  logic [AW-1:0]    i_wb_addr,
  input  logic [WIDTH-1:0] i_wb_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_busy
);

  logic w_hard_zero;
  logic w_fwd;

  assign w_hard_zero = (ZERO_REG != 0) && (i_addr == '0);

`ifdef R8B_REGFILE_BYPASS_EN
  // A hard-zero register must keep reading zero even while being "written".
  assign w_fwd = i_wb_en && (i_wb_addr == i_addr) && !w_hard_zero;
`else
  logic w_unused_wb;
  assign w_fwd       = 1'b0;
  assign w_unused_wb = ^{i_wb_en, i_wb_addr, i_wb_data, w_hard_zero};
`endif

  assign o_data = w_fwd ? i_wb_data : i_regs[i_addr];
  assign o_busy = i_busy_vec[i_addr] & ~w_fwd;

endmodule

// File: rtl/r8b_regfile.sv
// Multi-port GPR file with busy scoreboard for the r8b core.
// Optional same-cycle writeback forwarding: define R8B_REGFILE_BYPASS_EN.
import r8b_pkg::*;

module r8b_regfile #(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int NREGS    = DEF_NREGS,
  parameter  int ZERO_REG = 0,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic [AW-1:0]    lhs_addr,
  input  logic [AW-1:0]    rhs_addr,
  input  logic [AW-1:0]    bus_addr,
  output logic [WIDTH-1:0] lhs_data,
  output logic [WIDTH-1:0] rhs_data,
  output logic [WIDTH-1:0] bus_data,
  output logic             lhs_busy,
  output logic             rhs_busy,
  output logic             stall,
  output logic [NREGS-1:0] busy_vec,
  output logic             rsv_err
);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic             r_rsv_err;

  logic             w_wr_ok;
  logic             w_rsv_ok;
  logic [NREGS-1:0] w_busy_nxt;
  logic             w_rsv_err_nxt;
  logic             w_bus_busy_unused;

  assign w_wr_ok  = wb_en  && !((ZERO_REG != 0) && (wb_addr  == '0));
  assign w_rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  // NOTE: the register array is reset because a freshly reset core must read
  // zeros; for a large memory this reset would normally be omitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Reservation wins over writeback: a new producer is still outstanding.
  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    w_busy_nxt = r_busy;
    for (int i = 0; i < NREGS; i++) begin
      if (w_rsv_ok && (rsv_addr == AW'(i)))
        w_busy_nxt[i] = 1'b1;
      else if (wb_en && (wb_addr == AW'(i)))
        w_busy_nxt[i] = 1'b0;
    end
  end

  assign w_rsv_err_nxt = w_rsv_ok && r_busy[rsv_addr] &&
                         !(wb_en && (wb_addr == rsv_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= '0;
      r_rsv_err <= 1'b0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_rsv_err <= w_rsv_err_nxt;
    end
  end

  r8b_regfile_rdport #(.WIDTH(WIDTH), .NREGS(NREGS), .ZERO_REG(ZERO_REG)) u_lhs (
    .i_regs(r_regs), .i_busy_vec(r_busy), .i_addr(lhs_addr),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .o_data(lhs_data), .o_busy(lhs_busy)
  );

  r8b_regfile_rdport #(.WIDTH(WIDTH), .NREGS(NREGS), .ZERO_REG(ZERO_REG)) u_rhs (
    .i_regs(r_regs), .i_busy_vec(r_busy), .i_addr(rhs_addr),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .o_data(rhs_data), .o_busy(rhs_busy)
  );

  r8b_regfile_rdport #(.WIDTH(WIDTH), .NREGS(NREGS), .ZERO_REG(ZERO_REG)) u_bus (
    .i_regs(r_regs), .i_busy_vec(r_busy), .i_addr(bus_addr),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .o_data(bus_data), .o_busy(w_bus_busy_unused)
  );

  assign stall    = lhs_busy | rhs_busy;
  assign busy_vec = r_busy;
  assign rsv_err  = r_rsv_err;

endmodule

// File: tb/tb_r8b_regfile.sv
// Directed bench for r8b_regfile: vector table plus hand-written corner sequences.
import r8b_pkg::*;

module tb_r8b_regfile;

`ifdef R8B_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic      clk = 1'b0;
  logic      rst_n;
  logic      wb_en, rsv_en;
  reg_addr_t wb_addr, rsv_addr, lhs_addr, rhs_addr, bus_addr;
  reg_word_t wb_data;

  reg_word_t lhs_data, rhs_data, bus_data;
  logic      lhs_busy, rhs_busy, stall, rsv_err;
  logic [7:0] busy_vec;

  reg_word_t z_lhs_data, z_rhs_data, z_bus_data;
  logic      z_lhs_busy, z_rhs_busy, z_stall, z_rsv_err;
  logic [7:0] z_busy_vec;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  r8b_regfile dut (
    .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .lhs_addr(lhs_addr), .rhs_addr(rhs_addr),
    .bus_addr(bus_addr), .lhs_data(lhs_data), .rhs_data(rhs_data), .bus_data(bus_data),
    .lhs_busy(lhs_busy), .rhs_busy(rhs_busy), .stall(stall), .busy_vec(busy_vec),
    .rsv_err(rsv_err)
  );

  r8b_regfile #(.ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .lhs_addr(lhs_addr), .rhs_addr(rhs_addr),
    .bus_addr(bus_addr), .lhs_data(z_lhs_data), .rhs_data(z_rhs_data), .bus_data(z_bus_data),
    .lhs_busy(z_lhs_busy), .rhs_busy(z_rhs_busy), .stall(z_stall), .busy_vec(z_busy_vec),
    .rsv_err(z_rsv_err)
  );

  typedef struct {
    logic      wb_en;
    reg_addr_t wb_addr;
    reg_word_t wb_data;
    logic      rsv_en;
    reg_addr_t rsv_addr;
    reg_addr_t lhs_addr, rhs_addr, bus_addr;
    reg_word_t exp_lhs, exp_rhs, exp_bus;
    logic [7:0] exp_busy;
    logic      exp_stall;
    logic      exp_err;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input reg_addr_t wa, input reg_word_t wd,
                       input logic re, input reg_addr_t ra,
                       input reg_addr_t la, input reg_addr_t rb, input reg_addr_t ba);
    wb_en = we; wb_addr = wa; wb_data = wd;
    rsv_en = re; rsv_addr = ra;
    lhs_addr = la; rhs_addr = rb; bus_addr = ba;
  endtask

  function automatic vec_t mk(input logic we, input reg_addr_t wa, input reg_word_t wd,
                              input logic re, input reg_addr_t ra,
                              input reg_addr_t la, input reg_addr_t rb, input reg_addr_t ba,
                              input reg_word_t el, input reg_word_t er, input reg_word_t eb,
                              input logic [7:0] ebz, input logic es, input logic ee);
    vec_t v;
    v.wb_en = we; v.wb_addr = wa; v.wb_data = wd; v.rsv_en = re; v.rsv_addr = ra;
    v.lhs_addr = la; v.rhs_addr = rb; v.bus_addr = ba;
    v.exp_lhs = el; v.exp_rhs = er; v.exp_bus = eb;
    v.exp_busy = ebz; v.exp_stall = es; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    // Each row: inputs for this cycle, outputs expected before the next edge.
    //            wb  wa  wdata     rsv ra  lhs rhs bus  lhs      rhs      bus      busy   st  err
    tbl[0]  = mk(1, 3, 16'hBEEF, 0, 0,  0, 1, 2,  16'h0000, 16'h0000, 16'h0000, 8'h00, 0, 0);
    tbl[1]  = mk(0, 0, 16'h0000, 0, 0,  3, 3, 3,  16'hBEEF, 16'hBEEF, 16'hBEEF, 8'h00, 0, 0);
    tbl[2]  = mk(0, 0, 16'h0000, 1, 5,  3, 0, 3,  16'hBEEF, 16'h0000, 16'hBEEF, 8'h00, 0, 0);
    tbl[3]  = mk(0, 0, 16'h0000, 0, 0,  5, 3, 5,  16'h0000, 16'hBEEF, 16'h0000, 8'h20, 1, 0);
    tbl[4]  = mk(1, 5, 16'h1234, 0, 0,  3, 3, 3,  16'hBEEF, 16'hBEEF, 16'hBEEF, 8'h20, 0, 0);
    tbl[5]  = mk(0, 0, 16'h0000, 0, 0,  5, 5, 5,  16'h1234, 16'h1234, 16'h1234, 8'h00, 0, 0);
    tbl[6]  = mk(1, 2, 16'h00AA, 1, 2,  3, 5, 3,  16'hBEEF, 16'h1234, 16'hBEEF, 8'h00, 0, 0);
    tbl[7]  = mk(0, 0, 16'h0000, 0, 0,  2, 2, 2,  16'h00AA, 16'h00AA, 16'h00AA, 8'h04, 1, 0);
    tbl[8]  = mk(0, 0, 16'h0000, 1, 4,  1, 1, 1,  16'h0000, 16'h0000, 16'h0000, 8'h04, 0, 0);
    tbl[9]  = mk(0, 0, 16'h0000, 1, 4,  1, 1, 1,  16'h0000, 16'h0000, 16'h0000, 8'h14, 0, 0);
    tbl[10] = mk(0, 0, 16'h0000, 0, 0,  4, 0, 0,  16'h0000, 16'h0000, 16'h0000, 8'h14, 1, 1);
    tbl[11] = mk(0, 0, 16'h0000, 0, 0,  1, 1, 1,  16'h0000, 16'h0000, 16'h0000, 8'h14, 0, 0);
    tbl[12] = mk(1, 4, 16'h5555, 1, 4,  1, 1, 1,  16'h0000, 16'h0000, 16'h0000, 8'h14, 0, 0);
    tbl[13] = mk(0, 0, 16'h0000, 0, 0,  4, 4, 4,  16'h5555, 16'h5555, 16'h5555, 8'h14, 1, 0);
    tbl[14] = mk(1, 2, 16'h0F0F, 0, 0,  3, 1, 7,  16'hBEEF, 16'h0000, 16'h0000, 8'h14, 0, 0);
    tbl[15] = mk(0, 0, 16'h0000, 0, 0,  2, 4, 2,  16'h0F0F, 16'h5555, 16'h0F0F, 8'h10, 1, 0);
    tbl[16] = mk(1, 7, 16'h8001, 0, 0,  3, 3, 3,  16'hBEEF, 16'hBEEF, 16'hBEEF, 8'h10, 0, 0);
    tbl[17] = mk(0, 0, 16'h0000, 0, 0,  7, 2, 7,  16'h8001, 16'h0F0F, 16'h8001, 8'h10, 0, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    #1;
    check("reset_lhs", lhs_data, 0);
    check("reset_rhs", rhs_data, 0);
    check("reset_bus", bus_data, 0);
    check("reset_busy_vec", busy_vec, 0);
    check("reset_stall", stall, 0);
    check("reset_rsv_err", rsv_err, 0);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(tbl[i].wb_en, tbl[i].wb_addr, tbl[i].wb_data, tbl[i].rsv_en, tbl[i].rsv_addr,
            tbl[i].lhs_addr, tbl[i].rhs_addr, tbl[i].bus_addr);
      #1;
      check($sformatf("v%0d_lhs", i), lhs_data, tbl[i].exp_lhs);
      check($sformatf("v%0d_rhs", i), rhs_data, tbl[i].exp_rhs);
      check($sformatf("v%0d_bus", i), bus_data, tbl[i].exp_bus);
      check($sformatf("v%0d_busy_vec", i), busy_vec, tbl[i].exp_busy);
      check($sformatf("v%0d_stall", i), stall, tbl[i].exp_stall);
      check($sformatf("v%0d_rsv_err", i), rsv_err, tbl[i].exp_err);
    end

    // Asynchronous reset mid-operation drops reg7 and the pending reservation of reg4
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 7, 4, 7);
    rst_n = 1'b0;
    #1;
    check("midrst_lhs", lhs_data, 0);
    check("midrst_busy_vec", busy_vec, 0);
    check("midrst_stall", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_after_bus", bus_data, 0);

    // Hazard resolved by writeback, with or without forwarding
    @(negedge clk);
    drive(0, 0, 0, 1, 6, 6, 0, 6);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 6, 0, 6);
    #1;
    check("haz_lhs_busy", lhs_busy, 1);
    check("haz_stall", stall, 1);
    @(negedge clk);
    drive(1, 6, 16'h1234, 0, 0, 6, 0, 6);
    #1;
    check("wb_cycle_lhs", lhs_data, BYP ? 16'h1234 : 16'h0000);
    check("wb_cycle_bus", bus_data, BYP ? 16'h1234 : 16'h0000);
    check("wb_cycle_lhs_busy", lhs_busy, BYP ? 1'b0 : 1'b1);
    check("wb_cycle_stall", stall, BYP ? 1'b0 : 1'b1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 6, 0, 6);
    #1;
    check("after_wb_lhs", lhs_data, 16'h1234);
    check("after_wb_stall", stall, 0);

    // Same-cycle reserve and writeback: forwarded data, busy only from next cycle
    @(negedge clk);
    drive(1, 6, 16'h4321, 1, 6, 6, 6, 6);
    #1;
    check("rsvwb_lhs", lhs_data, BYP ? 16'h4321 : 16'h1234);
    check("rsvwb_rhs_busy", rhs_busy, 0);
    check("rsvwb_stall", stall, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 6, 6, 6);
    #1;
    check("rsvwb_next_lhs", lhs_data, 16'h4321);
    check("rsvwb_next_lhs_busy", lhs_busy, 1);
    check("rsvwb_next_busy6", busy_vec[6], 1);
    check("rsvwb_next_rsv_err", rsv_err, 0);

    // Hard-zero register 0 on the ZERO_REG=1 instance
    @(negedge clk);
    drive(1, 0, 16'hFFFF, 1, 0, 0, 0, 0);
    #1;
    check("zr_same_cycle_lhs", z_lhs_data, 0);
    check("zr_same_cycle_stall", z_stall, 0);
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    #1;
    check("zr_lhs", z_lhs_data, 0);
    check("zr_rhs", z_rhs_data, 0);
    check("zr_bus", z_bus_data, 0);
    check("zr_busy0", z_busy_vec[0], 0);
    check("zr_stall", z_stall, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("zr_rsv_err", z_rsv_err, 0);
    check("zr_lhs_busy", z_lhs_busy, 0);
    check("nz_reg0_written", lhs_data, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
